// File: rtl/fix_rx_pkg.sv
// Shared receive-side FIX definitions: parser states, error codes and ASCII constants.
package fix_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SKIP_BEGIN,
    TAG9,
    EQ9,
    DIGITS,
    BODY,
    DONE
  } state_e;

  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_NO_TAG9    = 3'd1;
  localparam logic [2:0] ERR_BAD_DIGITS = 3'd2;
  localparam logic [2:0] ERR_TOO_MANY   = 3'd3;
  localparam logic [2:0] ERR_MISMATCH   = 3'd4;
  localparam logic [2:0] ERR_OVERRUN    = 3'd5;

  localparam logic [7:0] ASCII_SOH = 8'h01;
  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [7:0] ASCII_1   = 8'h31;
  localparam logic [7:0] ASCII_9   = 8'h39;
  localparam logic [7:0] ASCII_EQ  = 8'h3D;

endpackage

// File: rtl/ascii_dec_accum.sv
// ASCII-decimal accumulator: validates digits, builds value*10+d and tracks the digit count.
module ascii_dec_accum
  import fix_rx_pkg::*;
#(
  parameter int LEN_WIDTH  = 20,
  parameter int MAX_DIGITS = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [7:0]           byte_i,
  output logic [LEN_WIDTH-1:0] value_o,
  output logic [3:0]           count_o,
  output logic                 is_digit_o,
  output logic                 full_o
);

  logic [LEN_WIDTH-1:0] value_q, value_d;
  logic [3:0]           count_q, count_d;
  logic [7:0]           digit;

  assign digit      = byte_i - ASCII_0;
  assign is_digit_o = (byte_i >= ASCII_0) && (byte_i <= ASCII_9);
  assign full_o     = (count_q == 4'(MAX_DIGITS));
  assign value_o    = value_q;
  assign count_o    = count_q;

  always_comb begin
    value_d = value_q;
    count_d = count_q;
    if (clr_i) begin
      value_d = '0;
      count_d = '0;
    end else if (en_i) begin
      // x10 as two shifts; wraps at LEN_WIDTH
      value_d = (value_q << 3) + (value_q << 1) + LEN_WIDTH'(digit);
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      count_q <= '0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fix_bodylength_checker.sv
// Receive-side FIX BodyLength checker: decodes tag 9 and counts body bytes up to "<SOH>10=".
// Optional BODYLENGTH_OVERRUN_EN aborts with code 5 once the body runs past value+3 bytes.
module fix_bodylength_checker
  import fix_rx_pkg::*;
#(
  parameter int LEN_WIDTH  = 20,
  parameter int MAX_DIGITS = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sof_i,
  input  logic [7:0]           byte_i,
  input  logic                 byte_valid_i,
  output logic [LEN_WIDTH-1:0] v_bodyLength_o,
  output logic [3:0]           l_v_bodyLength_o,
  output logic [LEN_WIDTH-1:0] measured_len_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [2:0]           err_code_o
);

  state_e               state_q;
  logic [LEN_WIDTH-1:0] cnt_q, meas_q;
  logic [23:0]          win_q;
  logic                 done_q, error_q;
  logic [2:0]           err_q;

  logic                 acc_clr, acc_en, is_digit, full;
  logic [LEN_WIDTH-1:0] value, cnt_d, meas_d;
  logic [3:0]           ndig;
  logic                 term_hit, overrun;

  function automatic logic [LEN_WIDTH-1:0] sat_inc(input logic [LEN_WIDTH-1:0] v);
    return (&v) ? v : v + LEN_WIDTH'(1);
  endfunction

  ascii_dec_accum #(
    .LEN_WIDTH (LEN_WIDTH),
    .MAX_DIGITS(MAX_DIGITS)
  ) u_accum (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (acc_clr),
    .en_i      (acc_en),
    .byte_i    (byte_i),
    .value_o   (value),
    .count_o   (ndig),
    .is_digit_o(is_digit),
    .full_o    (full)
  );

  assign acc_clr  = byte_valid_i && sof_i;
  assign acc_en   = byte_valid_i && !sof_i && (state_q == DIGITS) && is_digit && !full;
  assign cnt_d    = sat_inc(cnt_q);
  assign meas_d   = cnt_d - LEN_WIDTH'(3);
  assign term_hit = (byte_i == ASCII_EQ) && (win_q == {ASCII_SOH, ASCII_1, ASCII_0});

`ifdef BODYLENGTH_OVERRUN_EN
  logic [LEN_WIDTH:0] limit;
  assign limit   = {1'b0, value} + (LEN_WIDTH+1)'(3);
  assign overrun = ({1'b0, cnt_d} > limit);
`else
  assign overrun = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      meas_q  <= '0;
      win_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (state_q == DONE) state_q <= IDLE;
      // A start-of-frame byte restarts the parse from any state, silently
      if (byte_valid_i && sof_i) begin
        state_q <= SKIP_BEGIN;
        cnt_q   <= '0;
        meas_q  <= '0;
        win_q   <= '0;
        err_q   <= ERR_NONE;
      end else if (byte_valid_i) begin
        case (state_q)
          SKIP_BEGIN: if (byte_i == ASCII_SOH) state_q <= TAG9;
          TAG9: begin
            if (byte_i == ASCII_9) state_q <= EQ9;
            else begin error_q <= 1'b1; err_q <= ERR_NO_TAG9; state_q <= DONE; end
          end
          EQ9: begin
            if (byte_i == ASCII_EQ) state_q <= DIGITS;
            else begin error_q <= 1'b1; err_q <= ERR_NO_TAG9; state_q <= DONE; end
          end
          DIGITS: begin
            if (is_digit) begin
              if (full) begin error_q <= 1'b1; err_q <= ERR_TOO_MANY; state_q <= DONE; end
            end else if (byte_i == ASCII_SOH && ndig != 4'd0) begin
              // Seed the window with this SOH so an empty body ("9=0") still terminates
              state_q <= BODY;
              win_q   <= {16'h0000, ASCII_SOH};
            end else begin
              error_q <= 1'b1; err_q <= ERR_BAD_DIGITS; state_q <= DONE;
            end
          end
          BODY: begin
            cnt_q <= cnt_d;
            win_q <= {win_q[15:0], byte_i};
            if (term_hit) begin
              meas_q  <= meas_d;
              state_q <= DONE;
              if (meas_d == value) done_q <= 1'b1;
              else begin error_q <= 1'b1; err_q <= ERR_MISMATCH; end
            end else if (overrun) begin
              error_q <= 1'b1; err_q <= ERR_OVERRUN; state_q <= DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign v_bodyLength_o   = value;
  assign l_v_bodyLength_o = ndig;
  assign measured_len_o   = meas_q;
  assign done_o           = done_q;
  assign error_o          = error_q;
  assign err_code_o       = err_q;

endmodule

// File: tb/tb_fix_bodylength_checker.sv
// Testbench for fix_bodylength_checker; define BODYLENGTH_OVERRUN_EN to exercise the overrun abort.
module tb_fix_bodylength_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sof_i = 1'b0;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic [19:0] v_bodyLength_o;
  logic [3:0]  l_v_bodyLength_o;
  logic [19:0] measured_len_o;
  logic        done_o;
  logic        error_o;
  logic [2:0]  err_code_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_err;
    logic [2:0]  code;
    logic [19:0] val;
    logic [19:0] meas;
    logic [3:0]  nd;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  fix_bodylength_checker #(.LEN_WIDTH(20), .MAX_DIGITS(6)) dut (
    .clk             (clk),
    .rst             (rst),
    .sof_i           (sof_i),
    .byte_i          (byte_i),
    .byte_valid_i    (byte_valid_i),
    .v_bodyLength_o  (v_bodyLength_o),
    .l_v_bodyLength_o(l_v_bodyLength_o),
    .measured_len_o  (measured_len_o),
    .done_o          (done_o),
    .error_o         (error_o),
    .err_code_o      (err_code_o)
  );

  always #5 clk = ~clk;

  // Scoreboard: every pulse must match the oldest queued expectation
  always @(posedge clk) begin
    #1;
    if (done_o && error_o) begin
      checks++;
      errors++;
      $display("FAIL both_pulses done=%0b error=%0b required one-hot", done_o, error_o);
    end else if (done_o || error_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse done=%0b error=%0b code=%0d", done_o, error_o, err_code_o);
      end else begin
        e = sb.pop_front();
        if (error_o !== e.is_err || done_o !== !e.is_err || err_code_o !== e.code ||
            v_bodyLength_o !== e.val || measured_len_o !== e.meas || l_v_bodyLength_o !== e.nd) begin
          errors++;
          $display("FAIL pulse_result got err=%0b done=%0b code=%0d val=%0d meas=%0d nd=%0d required err=%0b code=%0d val=%0d meas=%0d nd=%0d",
                   error_o, done_o, err_code_o, v_bodyLength_o, measured_len_o, l_v_bodyLength_o,
                   e.is_err, e.code, e.val, e.meas, e.nd);
        end
      end
    end
  end

  task automatic push_exp(input bit is_err, input logic [2:0] code, input int val,
                          input int meas, input int nd);
    exp_t x;
    x.is_err = is_err; x.code = code; x.val = 20'(val); x.meas = 20'(meas); x.nd = 4'(nd);
    sb.push_back(x);
  endtask

  // '|' stands for SOH; first byte carries sof_i; stall inserts an idle cycle after each byte
  task automatic send_msg(input string s, input bit stall);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      byte_i       = (s[i] == 8'h7C) ? 8'h01 : s[i];
      sof_i        = (i == 0);
      byte_valid_i = 1'b1;
      if (stall) begin
        @(negedge clk);
        byte_valid_i = 1'b0;
        sof_i        = 1'b0;
      end
    end
    @(negedge clk);
    byte_valid_i = 1'b0;
    sof_i        = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout pending=%0d required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (v_bodyLength_o !== 20'd0 || l_v_bodyLength_o !== 4'd0 || measured_len_o !== 20'd0 ||
        done_o !== 1'b0 || error_o !== 1'b0 || err_code_o !== 3'd0) begin
      errors++;
      $display("FAIL %s got val=%0d nd=%0d meas=%0d done=%0b err=%0b code=%0d required all zero",
               name, v_bodyLength_o, l_v_bodyLength_o, measured_len_o, done_o, error_o, err_code_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset_hold");
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset_release");
  endtask

  task automatic test_good();
    push_exp(1'b0, 3'd0, 5, 5, 1);
    send_msg("8=FIX.4.2|9=5|35=0|10=123|", 1'b0);
    wait_drain("good");
    push_exp(1'b0, 3'd0, 11, 11, 2);
    send_msg("8=FIX.4.2|9=11|35=A|49=XY|10=000|", 1'b0);
    wait_drain("good_two_digit");
  endtask

  task automatic test_mismatch();
    push_exp(1'b1, 3'd4, 7, 5, 1);
    send_msg("8=FIX.4.2|9=7|35=0|10=123|", 1'b0);
    wait_drain("mismatch");
  endtask

  task automatic test_bad_value();
    push_exp(1'b1, 3'd2, 1, 0, 1);
    send_msg("8=FIX.4.2|9=1a5|35=0|", 1'b0);
    wait_drain("bad_digit");
    push_exp(1'b1, 3'd2, 0, 0, 0);
    send_msg("8=FIX.4.2|9=|35=0|", 1'b0);
    wait_drain("empty_digits");
    push_exp(1'b1, 3'd3, 123456, 0, 6);
    send_msg("8=FIX.4.2|9=1234567|35=0|", 1'b0);
    wait_drain("too_many_digits");
  endtask

  task automatic test_missing_tag9();
    push_exp(1'b1, 3'd1, 0, 0, 0);
    send_msg("8=FIX.4.2|35=0|", 1'b0);
    wait_drain("no_tag9");
    push_exp(1'b1, 3'd1, 0, 0, 0);
    send_msg("8=FIX.4.2|9x5|", 1'b0);
    wait_drain("no_eq9");
  endtask

  task automatic test_boundaries();
    push_exp(1'b0, 3'd0, 0, 0, 1);
    send_msg("8=FIX|9=0|10=000|", 1'b0);
    wait_drain("empty_body");
    // "x10=" inside the body lacks the leading SOH and must not terminate
    push_exp(1'b0, 3'd0, 8, 8, 1);
    send_msg("8=FIX|9=8|58=x10=|10=1|", 1'b0);
    wait_drain("false_terminator");
  endtask

  task automatic test_restart_stall();
    send_msg("8=FIX.4.2|9=5|35", 1'b0);
    push_exp(1'b0, 3'd0, 5, 5, 1);
    send_msg("8=FIX.4.2|9=5|35=0|10=123|", 1'b1);
    wait_drain("restart_stall");
  endtask

  task automatic test_reset_mid();
    send_msg("8=FIX.4.2|9=12", 1'b0);
    checks++;
    if (v_bodyLength_o !== 20'd12 || l_v_bodyLength_o !== 4'd2) begin
      errors++;
      $display("FAIL partial_digits got val=%0d nd=%0d required val=12 nd=2",
               v_bodyLength_o, l_v_bodyLength_o);
    end
    rst = 1'b1;
    @(negedge clk);
    check_zero("reset_mid_digits");
    rst = 1'b0;
    push_exp(1'b0, 3'd0, 5, 5, 1);
    send_msg("8=FIX.4.2|9=5|35=0|10=123|", 1'b0);
    wait_drain("after_reset");
  endtask

  task automatic test_overrun();
`ifdef BODYLENGTH_OVERRUN_EN
    push_exp(1'b1, 3'd5, 2, 0, 1);
`endif
    send_msg("8=FIX.4.2|9=2|ABCDEFGHIJ", 1'b0);
    wait_drain("overrun");
  endtask

  initial begin
    test_reset();
    test_good();
    test_mismatch();
    test_bad_value();
    test_missing_tag9();
    test_boundaries();
    test_restart_stall();
    test_reset_mid();
    test_overrun();
    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
